// File: rtl/param_queue_pkg.sv
// Shared definitions for the parametrised queue: pointer-width derivation,
// depth legality check and the per-cycle operation encoding.
package param_queue_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

  function automatic int q_log2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic bit q_is_pow2(input int value);
    return (value >= 32'sd2) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// Wrapping queue pointer: PW index bits plus one wrap bit, rolling over
// naturally modulo 2^(PW+1).
module queue_ptr #(
  parameter int PW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [PW:0] o_ptr
);

  logic [PW:0] r_ptr;

  // Pointer register: reset beats clear beats increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + (PW+1)'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/param_queue.sv
// Synchronous first-word-fall-through circular queue with occupancy count,
// almost-full/almost-empty thresholds, flush and sticky error flags.
module param_queue
  import param_queue_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [q_log2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = q_log2(DEPTH);
  localparam logic [PW:0] AF_THR = (PW+1)'(AF_LEVEL);
  localparam logic [PW:0] AE_THR = (PW+1)'(AE_LEVEL);

  generate
    if (!q_is_pow2(DEPTH)) begin : g_depth_check
      $error("param_queue: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [PW:0]      w_wp;
  logic [PW:0]      w_rp;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  q_op_e            w_op;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;

  assign w_empty   = (w_wp == w_rp);
  assign w_full    = (w_wp[PW-1:0] == w_rp[PW-1:0]) && (w_wp[PW] != w_rp[PW]);
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_push_ok = push && (!w_full || pop);
  assign w_pop_ok  = pop && !w_empty;
  assign w_op      = q_op_e'({w_push_ok, w_pop_ok});

  queue_ptr #(.PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (w_push_ok),
    .o_ptr (w_wp)
  );

  queue_ptr #(.PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (w_pop_ok),
    .o_ptr (w_rp)
  );

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset && !clear) begin
      r_mem[w_wp[PW-1:0]] <= din;
    end
  end

  // Occupancy counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_op)
        OP_PUSH: r_count <= r_count + (PW+1)'(1);
        OP_POP:  r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= r_overflow  || (push && !w_push_ok);
      r_underflow <= r_underflow || (pop && !w_pop_ok);
    end
  end

  assign dout         = w_empty ? '0 : r_mem[w_rp[PW-1:0]];
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_THR);
  assign almost_empty = (r_count <= AE_THR);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_queue.sv
// Checks three queue builds (8x8, 2x1, 16x32) against directed vector tables
// and a queue-based reference model under random push/pop traffic.
module tb_param_queue;

  logic        clk = 1'b0;
  logic        reset, clear, push, pop;
  logic [31:0] din_w;

  logic [7:0]  dout_a;
  logic [3:0]  count_a;
  logic        full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [0:0]  dout_b;
  logic [1:0]  count_b;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [31:0] dout_c;
  logic [4:0]  count_c;
  logic        full_c, empty_c, af_c, ae_c, ovf_c, unf_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_queue #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .din(din_w[7:0]), .pop(pop),
    .dout(dout_a), .full(full_a), .empty(empty_a), .count(count_a),
    .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a));

  param_queue #(.WIDTH(1), .DEPTH(2)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .din(din_w[0:0]), .pop(pop),
    .dout(dout_b), .full(full_b), .empty(empty_b), .count(count_b),
    .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b));

  param_queue #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .push(push), .din(din_w), .pop(pop),
    .dout(dout_c), .full(full_c), .empty(empty_c), .count(count_c),
    .almost_full(af_c), .almost_empty(ae_c), .overflow(ovf_c), .underflow(unf_c));

  // ---------------- reference model ----------------
  logic [31:0] q0[$], q1[$], q2[$];
  bit          m_ovf[3], m_unf[3];
  int          m_depth[3] = '{8, 2, 16};
  int          m_af[3]    = '{6, 1, 12};
  int          m_ae[3]    = '{1, 1, 3};
  logic [31:0] m_mask[3]  = '{32'hFF, 32'h1, 32'hFFFF_FFFF};

  function automatic logic [45:0] pack(input logic [31:0] d, input int c,
      input bit f, input bit e, input bit af, input bit ae, input bit ov, input bit un);
    return {d, 8'(c), f, e, af, ae, ov, un};
  endfunction

  task automatic model_step();
    logic [31:0] t[$];
    bit pa, pp, fl, em;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: t = q0;
        1: t = q1;
        default: t = q2;
      endcase
      if (reset || clear) begin
        t.delete();
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
      end else begin
        fl = (t.size() == m_depth[k]);
        em = (t.size() == 0);
        pa = push && (!fl || pop);
        pp = pop && !em;
        if (pp) void'(t.pop_front());
        if (pa) t.push_back(din_w & m_mask[k]);
        if (push && !pa) m_ovf[k] = 1'b1;
        if (pop && !pp)  m_unf[k] = 1'b1;
      end
      case (k)
        0: q0 = t;
        1: q1 = t;
        default: q2 = t;
      endcase
    end
  endtask

  task automatic check_model();
    logic [31:0] t[$];
    logic [45:0] exp_v, act_v;
    int c;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          t = q0;
          act_v = pack({24'h0, dout_a}, int'(count_a), full_a, empty_a, af_a, ae_a, ovf_a, unf_a);
        end
        1: begin
          t = q1;
          act_v = pack({31'h0, dout_b}, int'(count_b), full_b, empty_b, af_b, ae_b, ovf_b, unf_b);
        end
        default: begin
          t = q2;
          act_v = pack(dout_c, int'(count_c), full_c, empty_c, af_c, ae_c, ovf_c, unf_c);
        end
      endcase
      c = t.size();
      exp_v = pack((c > 0) ? t[0] : 32'h0, c, c == m_depth[k], c == 0,
                   c >= m_af[k], c <= m_ae[k], m_ovf[k], m_unf[k]);
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL model[dut%0d] t=%0t got dout=%h cnt=%0d flags=%b expected dout=%h cnt=%0d flags=%b",
                 k, $time, act_v[45:14], act_v[13:6], act_v[5:0], exp_v[45:14], exp_v[13:6], exp_v[5:0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // ---------------- directed vector table (8x8 build) ----------------
  typedef struct {
    bit         rst, clr, psh, pp;
    logic [7:0] d;
    logic [7:0] e_dout;
    int         e_cnt;
    bit         e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit clr, input bit psh, input bit pp,
      input logic [7:0] d, input logic [7:0] e_dout, input int e_cnt, input bit e_ovf, input bit e_unf);
    vec_t v;
    v.rst = rst; v.clr = clr; v.psh = psh; v.pp = pp; v.d = d;
    v.e_dout = e_dout; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [17:0] exp_t, act_t;
    int bias;

    // reset, then fill 0x11..0x88 and drain
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, 8'(17 * i), 8'h11, i, 0, 0);
    for (int j = 1; j <= 8; j++) add(0, 0, 0, 1, 8'h00, (j < 8) ? 8'(17 * (j + 1)) : 8'h00, 8 - j, 0, 0);
    // wrap: 5 in/out, then 8 more around the end of storage
    for (int i = 1; i <= 5; i++) add(0, 0, 1, 0, 8'(i), 8'h01, i, 0, 0);
    for (int j = 1; j <= 5; j++) add(0, 0, 0, 1, 8'h00, (j < 5) ? 8'(j + 1) : 8'h00, 5 - j, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 8'(8'hA0 + i), 8'hA0, i + 1, 0, 0);
    for (int j = 1; j <= 8; j++) add(0, 0, 0, 1, 8'h00, (j < 8) ? 8'(8'hA0 + j) : 8'h00, 8 - j, 0, 0);
    // full with simultaneous push(0x55) and pop; 0x55 drains last
    for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, 8'(17 * i), 8'h11, i, 0, 0);
    add(0, 0, 1, 1, 8'h55, 8'h22, 8, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, 1, 8'h00, (k < 7) ? 8'(17 * (k + 2)) : ((k == 7) ? 8'h55 : 8'h00), 8 - k, 0, 0);
    // empty with simultaneous push(0x3C) and pop, then overflow on a full queue
    add(0, 0, 1, 1, 8'h3C, 8'h3C, 1, 0, 1);
    for (int i = 1; i <= 7; i++) add(0, 0, 1, 0, 8'(8'h40 + i), 8'h3C, i + 1, 0, 1);
    add(0, 0, 1, 0, 8'h99, 8'h3C, 8, 1, 1);
    // drain to 4 with both flags set, flush (while pushing), then reset during push
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 1, 8'h00, 8'(8'h40 + k), 8 - k, 1, 1);
    add(0, 1, 1, 0, 8'h77, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h5A, 8'h5A, 1, 0, 0);
    add(0, 0, 1, 0, 8'h5B, 8'h5A, 2, 0, 0);
    add(1, 0, 1, 0, 8'hEE, 8'h00, 0, 0, 0);

    reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; din_w = 32'h0;
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      clear = vecs[i].clr;
      push  = vecs[i].psh;
      pop   = vecs[i].pp;
      din_w = {24'h0, vecs[i].d};
      tick();
      exp_t = {vecs[i].e_dout, 4'(vecs[i].e_cnt), vecs[i].e_cnt == 8, vecs[i].e_cnt == 0,
               vecs[i].e_cnt >= 6, vecs[i].e_cnt <= 1, vecs[i].e_ovf, vecs[i].e_unf};
      act_t = {dout_a, count_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a};
      n_vec++;
      if (act_t !== exp_t) begin
        n_err++;
        $display("FAIL table[%0d] got dout=%h cnt=%0d flags=%b expected dout=%h cnt=%0d flags=%b",
                 i, act_t[17:10], act_t[9:6], act_t[5:0], exp_t[17:10], exp_t[9:6], exp_t[5:0]);
      end
    end

    // random traffic with phases biased toward filling, draining and balance
    reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    tick();
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 100) == 0) begin
        case ($urandom_range(2))
          0: bias = 85;
          1: bias = 15;
          default: bias = 50;
        endcase
      end
      push  = ($urandom_range(99) < bias);
      pop   = ($urandom_range(99) < (100 - bias));
      clear = ($urandom_range(249) == 0);
      reset = ($urandom_range(799) == 0);
      din_w = $urandom();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
